conv_result_packer: RTL and testbench
=====================================

Name: conv_result_packer

Overview:
- Downstream stage of the convolution block.
- Takes the un-normalised MAC result (biased exponent plus wide magnitude) and normalises and rounds it to FP16 (1/EXP_SIZE/MANT_SIZE).
- Applies optional ReLU, then delivers results over a valid/ready stream through a small output FIFO.
- Tracks output-feature-map row/column position and flags end-of-row and end-of-frame for the write-back buffer.

Parameters:
- IMAGE_SIZE, 16: input image width/height; output map is OUT_W = IMAGE_SIZE-KERNEL_SIZE+1 square.
- KERNEL_SIZE, 3: convolution kernel size.
- EXP_SIZE, 5: FP16 exponent width; bias = 2^(EXP_SIZE-1)-1 = 15.
- MANT_SIZE, 10: FP16 fraction width.
- DATA_WIDTH, 16: packed output width.
- FIFO_DEPTH, 4: output FIFO entries (power of two).
- RELU_EN, 1: 1 = negative results forced to +0.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  result present on in_exp/in_sum/in_sign.
- in_ready  out  1  block can accept a result this cycle.
- in_exp  in  EXP_SIZE+1  biased exponent of the MAC result (0..63).
- in_sum  in  2*MANT_SIZE+1  unsigned magnitude, fixed point 2.19: value = in_sum/2^19 * 2^(in_exp-15).
- in_sign  in  1  result sign.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  DATA_WIDTH  packed FP16 result.
- out_last_col  out  1  head is last column of its row.
- out_last  out  1  head is last element of the frame.
- frame_done  out  1  one-cycle pulse after the out_last handshake.

Behaviour:
Handshake and pipeline
- Input accept = in_valid & in_ready. Output handshake = out_valid & out_ready.
- Pipeline is S1 (register inputs, leading-one detect) → S2 (shift, round, pack, ReLU) → FIFO. No stalls inside S1/S2.
- in_ready = (fifo_count + inflight) < FIFO_DEPTH, where inflight = number of valid S1/S2 stages.
- Latency: accept at cycle N gives out_valid at N+2 when the FIFO is empty. The FIFO must not be fall-through-bypassed.

Arithmetic
- p = index of the leading one of in_sum (0..20).
- e = in_exp + p - 19, held as a signed 8-bit value.
- Fraction = the 10 bits below p, zero-padded on the right if p < 10.
- Rounding: guard = next bit, sticky = OR of the rest; round to nearest, ties to even.
- Rounding carry out of the fraction sets fraction = 0 and e = e+1.
- in_sum == 0 → 0x0000.
- e ≤ 0 after rounding → flush to +0 (no subnormals).
- e ≥ 31 after rounding → saturate to {sign, 0x7BFF} (max finite, never Inf).
- RELU_EN=1 and sign=1 → 0x0000, including saturated negatives.

Position counters
- col and row advance on each output handshake. Both are 0..OUT_W-1.
- col wraps to 0 and increments row. row wraps to 0 after the last element.
- out_last_col = (col == OUT_W-1). out_last = out_last_col & (row == OUT_W-1).
- frame_done is registered and asserted the cycle after the out_last handshake.

FIFO
- Pointer-based, full/empty derived from count.
- Simultaneous push and pop when full is impossible by construction (in_ready guard).
- Simultaneous push and pop in any other state: count unchanged.

Reset (async assert, sync release)
- S1/S2 valid = 0, FIFO empty, count = 0, col = row = 0.
- out_valid = 0, out_data = 0, out_last_col = 0, out_last = 0, frame_done = 0.
- in_ready = 1 from the first cycle after release.
- Reset mid-frame discards in-flight and queued results and restarts the position at (0,0).

Decomposition:
- Package conv_pkg: FP16 constants (EXP_BIAS = 15, FP16_MAX_POS = 16'h7BFF, FP16_ZERO = 16'h0000) and an fp16_t packed struct {sign, exp[4:0], frac[9:0]}.
- One sub-module: sync_fifo (parameterised width/depth, count output), reused by later stages.
- Normaliser/rounder stays inline.

Test Plan:
- Exact values: in_exp=15, in_sum=1<<19, sign=0 → 0x3C00 two cycles later. in_exp=16, in_sum=3<<18 → 0x4200 (3.0).
- Rounding carry: in_exp=15, in_sum=21'h0FFFFF → 0x4000. in_sum=(1<<19)|(1<<8) (tie, even LSB) → 0x3C00.
- Boundaries: in_sum=0 → 0x0000. in_exp=40, in_sum=1<<19 → 0x7BFF. in_exp=2, in_sum=1<<10 → 0x0000 (underflow). sign=1 with RELU_EN=1 → 0x0000; RELU_EN=0 → 0xBC00.
- Backpressure: out_ready=0 with continuous in_valid → exactly 4 accepts, then in_ready=0. Release out_ready → 4 results in order, no loss or duplication.
- Frame: stream 196 results (OUT_W=14) with random out_ready → out_last_col on every 14th, out_last only on the 196th, frame_done one cycle after it, next result reports col=0/row=0.
- Reset: assert rst low mid-frame with 3 entries queued → out_valid=0 immediately; after release, the next result is position (0,0) and no stale data appears.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared FP16 constants and the packed half-precision layout used by the
// convolution output stages.
package conv_pkg;

    localparam int EXP_BIAS = 15;
    // Largest biased exponent: 2*bias+1 is the Inf/NaN code and is never emitted
    localparam int EXP_MAX = 2 * EXP_BIAS + 1;

    localparam logic [15:0] FP16_MAX_POS = 16'h7BFF;
    localparam logic [15:0] FP16_ZERO    = 16'h0000;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

endpackage

// File: rtl/sync_fifo.sv
// Pointer-based synchronous FIFO with an occupancy count; registered storage,
// so a write becomes visible at the head on the following cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/conv_result_packer.sv
// Normalises and rounds raw MAC results to FP16, applies optional ReLU, and
// streams them out through a small FIFO with row/column position flags.
module conv_result_packer
    import conv_pkg::*;
#(
    parameter int IMAGE_SIZE  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int EXP_SIZE    = 5,
    parameter int MANT_SIZE   = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int RELU_EN     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_SIZE:0]      in_exp,
    input  logic [2*MANT_SIZE:0]   in_sum,
    input  logic                   in_sign,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last_col,
    output logic                   out_last,
    output logic                   frame_done
);

    localparam int OUT_W  = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int POS_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int SUM_W  = 2 * MANT_SIZE + 1;
    localparam int POINT  = 2 * MANT_SIZE - 1;
    localparam int LEAD_W = $clog2(SUM_W);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic                  accept;
    logic                  pop;
    logic [LEAD_W-1:0]     lead;

    logic                  s1_valid;
    logic [EXP_SIZE:0]     s1_exp;
    logic [SUM_W-1:0]      s1_sum;
    logic                  s1_sign;
    logic [LEAD_W-1:0]     s1_lead;

    logic [SUM_W-2:0]      below;
    logic [MANT_SIZE-1:0]  frac;
    logic                  guard;
    logic                  sticky;
    logic                  round_up;
    logic [MANT_SIZE:0]    frac_rnd;
    logic signed [7:0]     exp_pre;
    logic signed [7:0]     exp_rnd;
    fp16_t                 result;
    logic [DATA_WIDTH-1:0] s2_data;

    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;

    logic [POS_W-1:0]      col;
    logic [POS_W-1:0]      row;

    // Inflight is just S1: S2 is combinational and lands directly in the FIFO
    assign in_ready = ({1'b0, fifo_count} + (CNT_W+1)'(s1_valid)) < (CNT_W+1)'(FIFO_DEPTH);
    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    always_comb begin
        lead = '0;
        for (int i = 0; i < SUM_W; i++) begin
            if (in_sum[i]) lead = LEAD_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_exp   <= '0;
            s1_sum   <= '0;
            s1_sign  <= 1'b0;
            s1_lead  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_exp  <= in_exp;
                s1_sum  <= in_sum;
                s1_sign <= in_sign;
                s1_lead <= lead;
            end
        end
    end

    // Left-justify so the leading one falls off the top; what remains is the
    // fraction followed by guard and sticky bits, zero-padded when p is small
    always_comb begin
        below    = (SUM_W-1)'(s1_sum << (LEAD_W'(SUM_W - 1) - s1_lead));
        frac     = below[SUM_W-2 -: MANT_SIZE];
        guard    = below[SUM_W-2-MANT_SIZE];
        sticky   = |below[SUM_W-3-MANT_SIZE:0];
        round_up = guard & (sticky | frac[0]);
        frac_rnd = {1'b0, frac} + (MANT_SIZE+1)'(round_up);
        exp_pre  = signed'(8'(s1_exp) + 8'(s1_lead) - 8'(POINT));
        exp_rnd  = exp_pre + (frac_rnd[MANT_SIZE] ? 8'sd1 : 8'sd0);

        result.sign = s1_sign;
        result.exp  = exp_rnd[EXP_SIZE-1:0];
        result.frac = frac_rnd[MANT_SIZE-1:0];
        if (s1_sum == '0 || exp_rnd <= 8'sd0) begin
            result = FP16_ZERO;
        end else if (exp_rnd >= signed'(8'(EXP_MAX))) begin
            result = {s1_sign, FP16_MAX_POS[14:0]};
        end
        if (RELU_EN != 0 && s1_sign) begin
            result = FP16_ZERO;
        end
        s2_data = DATA_WIDTH'(result);
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid),
        .push_data (s2_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign out_valid    = ~fifo_empty;
    assign out_data     = out_valid ? fifo_head : '0;
    assign out_last_col = out_valid & (col == POS_W'(OUT_W - 1));
    assign out_last     = out_last_col & (row == POS_W'(OUT_W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop & out_last;
            if (pop) begin
                if (col == POS_W'(OUT_W - 1)) begin
                    col <= '0;
                    row <= (row == POS_W'(OUT_W - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_result_packer.sv
// Self-checking bench: directed vector table, latency/backpressure/reset
// sequences, and a randomized frame checked against a real-arithmetic model.
module tb_conv_result_packer;

    localparam int OUT_W = 14;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_exp;
    logic [20:0] in_sum;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last_col;
    logic        out_last;
    logic        frame_done;

    logic        nr_in_ready;
    logic        nr_out_valid;
    logic [15:0] nr_out_data;
    logic        nr_out_last_col;
    logic        nr_out_last;
    logic        nr_frame_done;

    int total = 0;
    int bad   = 0;

    logic [15:0] cur_exp;
    logic [15:0] cur_nr;
    logic [15:0] exp_q[$];
    logic [15:0] nr_q[$];
    int          mcol = 0;
    int          mrow = 0;
    bit          fd_pending = 0;
    int          npops = 0;
    int          lastcols = 0;
    int          lasts = 0;

    typedef struct {
        logic [5:0]  exp;
        logic [20:0] sum;
        logic        sign;
        logic [15:0] relu_out;
        logic [15:0] raw_out;
    } vec_t;

    vec_t vecs [16];

    conv_result_packer #(.RELU_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_exp(in_exp), .in_sum(in_sum), .in_sign(in_sign),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last_col(out_last_col), .out_last(out_last), .frame_done(frame_done)
    );

    conv_result_packer #(.RELU_EN(0)) dut_nr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nr_in_ready),
        .in_exp(in_exp), .in_sum(in_sum), .in_sign(in_sign),
        .out_valid(nr_out_valid), .out_ready(out_ready), .out_data(nr_out_data),
        .out_last_col(nr_out_last_col), .out_last(nr_out_last), .frame_done(nr_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Value = s * 2^(e-34); normalise to [1,2) and round the scaled fraction
    function automatic logic [15:0] refModel(input int e, input int s, input bit sg, input bit relu);
        real m, f, fl, rem;
        int  ex, fr, biased;
        if (s == 0) return 16'h0000;
        m  = real'(s);
        ex = e - 34;
        while (m >= 2.0) begin
            m  = m / 2.0;
            ex = ex + 1;
        end
        f   = (m - 1.0) * 1024.0;
        fl  = $floor(f);
        rem = f - fl;
        fr  = int'(fl);
        if (rem > 0.5 || (rem == 0.5 && (fr % 2) == 1)) fr = fr + 1;
        if (fr == 1024) begin
            fr = 0;
            ex = ex + 1;
        end
        biased = ex + 15;
        if (sg && relu) return 16'h0000;
        if (biased <= 0) return 16'h0000;
        if (biased >= 31) return {sg, 15'h7BFF};
        return {sg, biased[4:0], fr[9:0]};
    endfunction

    task automatic genRandom();
        if ($urandom_range(0, 1) == 1) in_exp = 6'($urandom_range(8, 30));
        else                           in_exp = 6'($urandom_range(0, 63));
        in_sum  = 21'($urandom_range(0, 2097151) >> $urandom_range(0, 21));
        in_sign = 1'($urandom_range(0, 1));
        cur_exp = refModel(int'(in_exp), int'(in_sum), in_sign, 1'b1);
        cur_nr  = refModel(int'(in_exp), int'(in_sum), in_sign, 1'b0);
    endtask

    // Drives one result and returns just after the edge that accepted it
    task automatic applyStimulus(input logic [5:0] e, input logic [20:0] s, input logic sg,
                                 input logic [15:0] er, input logic [15:0] enr);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_exp   = e;
        in_sum   = s;
        in_sign  = sg;
        cur_exp  = er;
        cur_nr   = enr;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic streamRandom(input int n, input bit rand_ready);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < 20 * n + 50) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                genRandom();
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            cyc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (acc < n) checkOutput("stream_timeout", 32'(acc), 32'(n));
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst        = 1'b0;
        in_valid   = 1'b0;
        exp_q.delete();
        nr_q.delete();
        mcol       = 0;
        mrow       = 0;
        fd_pending = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Scoreboard: record accepted expectations, compare on each output handshake
    always @(negedge clk) begin
        if (rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                nr_q.push_back(cur_nr);
            end
            if (frame_done || fd_pending) checkOutput("frame_done", 32'(frame_done), 32'(fd_pending));
            if (nr_frame_done || fd_pending) checkOutput("nr_frame_done", 32'(nr_frame_done), 32'(fd_pending));
            fd_pending = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_output actual=%0h required=none", out_data);
                end else begin
                    checkOutput("data", 32'(out_data), 32'(exp_q.pop_front()));
                    checkOutput("nr_data", 32'(nr_out_data), 32'(nr_q.pop_front()));
                    checkOutput("nr_valid", 32'(nr_out_valid), 32'd1);
                    checkOutput("last_col", 32'(out_last_col), 32'(mcol == OUT_W - 1));
                    checkOutput("last", 32'(out_last), 32'(mcol == OUT_W - 1 && mrow == OUT_W - 1));
                    checkOutput("nr_last", 32'(nr_out_last), 32'(mcol == OUT_W - 1 && mrow == OUT_W - 1));
                    checkOutput("nr_last_col", 32'(nr_out_last_col), 32'(mcol == OUT_W - 1));
                    npops++;
                    if (mcol == OUT_W - 1) begin
                        lastcols++;
                        mcol = 0;
                        if (mrow == OUT_W - 1) begin
                            lasts++;
                            fd_pending = 1;
                            mrow = 0;
                        end else begin
                            mrow++;
                        end
                    end else begin
                        mcol++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc;
        int p0, lc0, l0;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_exp    = '0;
        in_sum    = '0;
        in_sign   = 1'b0;
        out_ready = 1'b0;
        cur_exp   = '0;
        cur_nr    = '0;

        vecs[0]  = '{6'd15, 21'h080000,  1'b0, 16'h3C00, 16'h3C00};
        vecs[1]  = '{6'd16, 21'h0C0000,  1'b0, 16'h4200, 16'h4200};
        vecs[2]  = '{6'd15, 21'h0FFFFF,  1'b0, 16'h4000, 16'h4000};
        vecs[3]  = '{6'd15, 21'h080100,  1'b0, 16'h3C00, 16'h3C00};
        vecs[4]  = '{6'd15, 21'h080300,  1'b0, 16'h3C02, 16'h3C02};
        vecs[5]  = '{6'd20, 21'h000000,  1'b1, 16'h0000, 16'h0000};
        vecs[6]  = '{6'd40, 21'h080000,  1'b0, 16'h7BFF, 16'h7BFF};
        vecs[7]  = '{6'd2,  21'h000400,  1'b0, 16'h0000, 16'h0000};
        vecs[8]  = '{6'd15, 21'h080000,  1'b1, 16'h0000, 16'hBC00};
        vecs[9]  = '{6'd40, 21'h080000,  1'b1, 16'h0000, 16'hFBFF};
        vecs[10] = '{6'd0,  21'h100000,  1'b0, 16'h0400, 16'h0400};
        vecs[11] = '{6'd19, 21'h000001,  1'b0, 16'h0000, 16'h0000};
        vecs[12] = '{6'd19, 21'h000003,  1'b0, 16'h0600, 16'h0600};
        vecs[13] = '{6'd29, 21'h100000,  1'b0, 16'h7800, 16'h7800};
        vecs[14] = '{6'd29, 21'h1FFFFF,  1'b0, 16'h7BFF, 16'h7BFF};
        vecs[15] = '{6'd16, 21'h0C0000,  1'b1, 16'h0000, 16'hC200};

        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        checkOutput("reset_last_col", 32'(out_last_col), 32'd0);
        checkOutput("reset_last", 32'(out_last), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] latency sequence");
        out_ready = 1'b1;
        applyStimulus(6'd15, 21'h080000, 1'b0, 16'h3C00, 16'h3C00);
        @(negedge clk);
        checkOutput("latency_n1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("latency_n2_valid", 32'(out_valid), 32'd1);
        checkOutput("latency_n2_data", 32'(out_data), 32'h3C00);
        waitDrain(20);

        $display("[TB] vector table");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].exp, vecs[i].sum, vecs[i].sign, vecs[i].relu_out, vecs[i].raw_out);
            waitDrain(20);
        end

        $display("[TB] backpressure");
        doReset();
        out_ready = 1'b0;
        acc = 0;
        p0 = npops;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            genRandom();
            @(negedge clk);
            if (in_valid && in_ready) acc++;
        end
        checkOutput("bp_accepts", 32'(acc), 32'd4);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_nr_in_ready", 32'(nr_in_ready), 32'd0);
        @(posedge clk);
        #1;
        waitDrain(40);
        repeat (3) @(negedge clk);
        checkOutput("bp_pops", 32'(npops - p0), 32'd4);
        checkOutput("bp_no_dup", 32'(out_valid), 32'd0);

        $display("[TB] random frame");
        doReset();
        lc0 = lastcols;
        l0  = lasts;
        streamRandom(OUT_W * OUT_W, 1'b1);
        waitDrain(200);
        repeat (2) @(negedge clk);
        checkOutput("frame_lastcols", 32'(lastcols - lc0), 32'(OUT_W));
        checkOutput("frame_lasts", 32'(lasts - l0), 32'd1);
        streamRandom(3, 1'b1);
        waitDrain(50);

        $display("[TB] reset mid-frame");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            genRandom();
            applyStimulus(in_exp, in_sum, in_sign, cur_exp, cur_nr);
        end
        repeat (2) @(negedge clk);
        checkOutput("queued_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_last_col", 32'(out_last_col), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        exp_q.delete();
        nr_q.delete();
        mcol = 0;
        mrow = 0;
        fd_pending = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_release_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("rst_no_stale", 32'(out_valid), 32'd0);
        lc0 = lastcols;
        streamRandom(OUT_W, 1'b1);
        waitDrain(100);
        checkOutput("rst_row_lastcols", 32'(lastcols - lc0), 32'd1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
